// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The fetch unit is the master: it issues word requests on a valid/ready
// handshake and receives in-order responses without backpressure.
interface fetch_unit_if #(
  parameter int ADDRESS_BITS = 20
);
  logic                    imem_req_valid;
  logic                    imem_req_ready;
  logic [ADDRESS_BITS-1:0] imem_req_addr;
  logic                    imem_rsp_valid;
  logic [31:0]             imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues sequential word requests
// to imem under a credit limit, buffers in-order responses in a small queue
// and presents the queue head to decode. Redirects flush the queue and drop
// responses that are still in flight.
// Optional feature: define FETCH_BYPASS_EN to let a response that finds the
// queue empty go straight to the decode outputs in the same cycle.
module fetch_unit #(
  parameter int                      CORE         = 0,
  parameter int                      ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter int                      QUEUE_DEPTH  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] start_PC,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  fetch_unit_if.master            imem,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instruction,
  output logic                    inst_valid,
  input  logic                    stall,
  input  logic                    report
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(4);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [ADDRESS_BITS-1:0] fetch_pc;
  logic [ADDRESS_BITS-1:0] rsp_pc;
  logic [CNT_W-1:0]        outstanding;
  logic [CNT_W-1:0]        drop_count;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [ADDRESS_BITS-1:0] pc_q   [QUEUE_DEPTH];
  logic [31:0]             data_q [QUEUE_DEPTH];

  logic             run;
  logic [SUM_W-1:0] in_use;
  logic             credit;
  logic             req_valid;
  logic             accept;
  logic             rsp;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             head_valid;
  logic             pop;
  logic             bypass_hit;
  logic             enq;

  // report and CORE only serve simulation-side tracing and carry no logic.
  logic unused_ok;
  assign unused_ok = ^{report, CORE[0]};

  // Every request holds a credit until its response is either queued and
  // popped or dropped, so a response always finds a free queue slot.
  assign run        = (state == RUN);
  assign in_use     = SUM_W'(outstanding) + SUM_W'(count) + SUM_W'(drop_count);
  assign credit     = in_use < SUM_W'(QUEUE_DEPTH);
  assign req_valid  = run && credit && !redirect;
  assign accept     = req_valid && imem.imem_req_ready;
  assign rsp        = run && imem.imem_rsp_valid;
  assign rsp_keep   = rsp && (drop_count == '0);
  assign rsp_drop   = rsp && (drop_count != '0);
  assign head_valid = (count != '0);
  assign pop        = head_valid && !stall;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rsp_keep && !head_valid && !stall && !redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  assign enq = rsp_keep && !bypass_hit;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc;

  // Decode sees the queue head, or the arriving word when it bypasses the queue.
  always_comb begin
    PC          = pc_q[head];
    instruction = head_valid ? data_q[head] : NOP;
    inst_valid  = head_valid;
    if (bypass_hit) begin
      PC          = rsp_pc;
      instruction = imem.imem_rsp_data;
      inst_valid  = 1'b1;
    end
  end

  // Control FSM, PCs, credit counters and instruction queue; redirect wins over everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]   <= RESET_PC;
        data_q[i] <= NOP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            fetch_pc <= start_PC;
            rsp_pc   <= start_PC;
          end
        end
        RUN: begin
          if (redirect) begin
            fetch_pc    <= redirect_target;
            rsp_pc      <= redirect_target;
            outstanding <= '0;
            drop_count  <= drop_count + outstanding - CNT_W'(rsp);
            count       <= '0;
            head        <= '0;
            tail        <= '0;
          end else begin
            if (accept) begin
              fetch_pc <= fetch_pc + STEP;
            end
            if (rsp_keep) begin
              rsp_pc <= rsp_pc + STEP;
            end
            if (rsp_drop) begin
              drop_count <= drop_count - CNT_W'(1);
            end
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_keep);
            if (enq) begin
              pc_q[tail]   <= rsp_pc;
              data_q[tail] <= imem.imem_rsp_data;
              tail         <= tail + PTR_W'(1);
            end
            if (pop) begin
              head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(pop);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scripted cycle table, hand-written
// redirect/latency/wrap/reset sequences, and a randomized run checked
// against a stream-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int QD = 2;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VALID_LAT = 2;
`else
  localparam int FIRST_VALID_LAT = 3;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [19:0] start_pc;
  logic        redirect;
  logic [19:0] redirect_target;
  logic        stall;
  logic        report;
  logic [19:0] pc;
  logic [31:0] instruction;
  logic        inst_valid;

  fetch_unit_if #(.ADDRESS_BITS(20)) imem_bus ();

  fetch_unit #(
    .CORE(0), .ADDRESS_BITS(20), .RESET_PC(20'h00000), .QUEUE_DEPTH(QD)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .start_PC(start_pc),
    .redirect(redirect), .redirect_target(redirect_target), .imem(imem_bus),
    .PC(pc), .instruction(instruction), .inst_valid(inst_valid),
    .stall(stall), .report(report)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic        stl;
    logic        rv;
    logic [19:0] raddr;
    logic        exp_req_valid;
    logic [19:0] exp_req_addr;
    logic        exp_valid;
    logic [19:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [19:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  int vectors = 0;
  int miscompares = 0;

  mem_req_t    pending[$];
  logic [19:0] acc_log[$];
  int          cycle = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          pops = 0;
  int          s_cycle = 0;
  logic        model_run = 1'b0;
  logic        s_req_valid = 1'b0;
  logic        s_inst_valid = 1'b0;
  logic [19:0] exp_req_addr = '0;
  logic [19:0] exp_pc = '0;
  logic [19:0] last_pop_pc = '0;

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {12'hC5A, a};
  endfunction

  function automatic logic [19:0] next_addr(input logic [19:0] a);
    int v;
    v = (int'(a) + 4) % (1 << 20);
    return v[19:0];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic check_reset_values(input string name);
    checkOutput(name,
      128'({imem_bus.imem_req_valid, imem_bus.imem_req_addr, inst_valid, pc, instruction}),
      128'({1'b0, 20'h00000, 1'b0, 20'h00000, NOP}));
  endtask

  task automatic clear_model();
    pending.delete();
    acc_log.delete();
    buffered  = 0;
    epoch     = 0;
    pops      = 0;
    model_run = 1'b0;
  endtask

  task automatic drive_idle();
    start = 1'b0; start_pc = '0; redirect = 1'b0; redirect_target = '0; stall = 1'b0;
    imem_bus.imem_req_ready = 1'b1;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    clear_model();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Manual drive at the negedge, outputs settle 1 time unit later.
  task automatic applyStimulus(input logic st, input logic stl, input logic rv, input logic [19:0] raddr,
                               input logic rd, input logic [19:0] addr);
    start = st; start_pc = addr; redirect = rd; redirect_target = addr; stall = stl;
    imem_bus.imem_req_ready = 1'b1;
    imem_bus.imem_rsp_valid = rv;
    imem_bus.imem_rsp_data  = rv ? mem_word(raddr) : 32'h0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One cycle with the in-order memory model and the stream reference model.
  task automatic step_auto(input logic st, input logic stl, input logic rd, input logic [19:0] addr, input logic rdy);
    logic        rsp_now;
    logic        accept_now;
    logic        pop_now;
    logic [19:0] req_addr;
    int          rsp_epoch;
    start = st; start_pc = addr; redirect = rd; redirect_target = addr; stall = stl;
    imem_bus.imem_req_ready = rdy;
    rsp_now   = (pending.size() > 0) && (pending[0].due <= cycle);
    rsp_epoch = rsp_now ? pending[0].epoch : -1;
    imem_bus.imem_rsp_valid = rsp_now;
    imem_bus.imem_rsp_data  = rsp_now ? mem_word(pending[0].addr) : 32'h0;
    #1;
    s_cycle      = cycle;
    s_req_valid  = imem_bus.imem_req_valid;
    s_inst_valid = inst_valid;
    req_addr     = imem_bus.imem_req_addr;
    accept_now   = imem_bus.imem_req_valid && rdy;
    pop_now      = inst_valid && !stl && !rd;
    if (rd) checkOutput("req_in_redirect_cycle", 128'(imem_bus.imem_req_valid), 128'(1'b0));
    if (!inst_valid) checkOutput("nop_when_invalid", 128'(instruction), 128'(NOP));
    if (accept_now) begin
      checkOutput("req_addr", 128'(req_addr), 128'(exp_req_addr));
      acc_log.push_back(req_addr);
      exp_req_addr = next_addr(exp_req_addr);
    end
    if (pop_now) begin
      checkOutput("pop_pc_data", 128'({pc, instruction}), 128'({exp_pc, mem_word(exp_pc)}));
      last_pop_pc = pc;
      exp_pc = next_addr(exp_pc);
      pops++;
      buffered--;
    end
    if (rsp_now && rsp_epoch == epoch) buffered++;
    if (rd && model_run) begin
      epoch++;
      buffered = 0;
      exp_pc = addr;
      exp_req_addr = addr;
    end
    if (st && !model_run) begin
      model_run = 1'b1;
      exp_pc = addr;
      exp_req_addr = addr;
    end
    @(posedge clock);
    if (rsp_now) void'(pending.pop_front());
    if (accept_now) pending.push_back('{addr: req_addr, due: cycle + $urandom_range(lat_max, lat_min), epoch: epoch});
    checkOutput("credit_bound", 128'(pending.size() + buffered <= QD), 128'(1'b1));
    cycle++;
    @(negedge clock);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        table_vecs[13];
    int          start_cycle;
    int          first_req;
    int          first_valid;
    int          pops_before;
    int          guard;
    logic [19:0] t;

    reset = 1'b0;
    report = 1'b0;
    drive_idle();
    #1;
    check_reset_values("reset_values");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // start 0x100, latency 1, stall holds the queue full, then drains.
    table_vecs[0]  = '{1'b1, 1'b1, 1'b0, 20'h000, 1'b0, 20'h000, 1'b0, 20'h000};
    table_vecs[1]  = '{1'b0, 1'b1, 1'b0, 20'h000, 1'b1, 20'h100, 1'b0, 20'h000};
    table_vecs[2]  = '{1'b0, 1'b1, 1'b1, 20'h100, 1'b1, 20'h104, 1'b0, 20'h000};
    table_vecs[3]  = '{1'b0, 1'b1, 1'b1, 20'h104, 1'b0, 20'h108, 1'b1, 20'h100};
    table_vecs[4]  = '{1'b0, 1'b1, 1'b0, 20'h000, 1'b0, 20'h108, 1'b1, 20'h100};
    table_vecs[5]  = '{1'b0, 1'b0, 1'b0, 20'h000, 1'b0, 20'h108, 1'b1, 20'h100};
    table_vecs[6]  = '{1'b0, 1'b1, 1'b0, 20'h000, 1'b1, 20'h108, 1'b1, 20'h104};
    table_vecs[7]  = '{1'b0, 1'b1, 1'b1, 20'h108, 1'b0, 20'h10C, 1'b1, 20'h104};
    table_vecs[8]  = '{1'b0, 1'b0, 1'b0, 20'h000, 1'b0, 20'h10C, 1'b1, 20'h104};
    table_vecs[9]  = '{1'b0, 1'b0, 1'b0, 20'h000, 1'b1, 20'h10C, 1'b1, 20'h108};
    table_vecs[10] = '{1'b0, 1'b1, 1'b1, 20'h10C, 1'b1, 20'h110, 1'b0, 20'h000};
    table_vecs[11] = '{1'b0, 1'b0, 1'b1, 20'h110, 1'b0, 20'h114, 1'b1, 20'h10C};
    table_vecs[12] = '{1'b0, 1'b0, 1'b0, 20'h000, 1'b1, 20'h114, 1'b1, 20'h110};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(table_vecs[i].st, table_vecs[i].stl, table_vecs[i].rv, table_vecs[i].raddr, 1'b0, 20'h100);
      checkOutput($sformatf("table_row_%0d", i),
        128'({imem_bus.imem_req_valid, imem_bus.imem_req_addr, inst_valid, inst_valid ? pc : 20'h0, instruction}),
        128'({table_vecs[i].exp_req_valid, table_vecs[i].exp_req_addr, table_vecs[i].exp_valid,
              table_vecs[i].exp_valid ? table_vecs[i].exp_pc : 20'h0,
              table_vecs[i].exp_valid ? mem_word(table_vecs[i].exp_pc) : NOP}));
      next_cycle();
    end

    // Redirect coinciding with a response and a would-be pop.
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 20'h100);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 20'h0);
    checkOutput("rd_first_req", 128'({imem_bus.imem_req_valid, imem_bus.imem_req_addr}), 128'({1'b1, 20'h100}));
    next_cycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 20'h100, 1'b0, 20'h0);
    checkOutput("rd_second_req", 128'({imem_bus.imem_req_valid, imem_bus.imem_req_addr}), 128'({1'b1, 20'h104}));
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 20'h104, 1'b1, 20'h200);
    checkOutput("rd_redirect_cycle", 128'({imem_bus.imem_req_valid, inst_valid, pc}), 128'({1'b0, 1'b1, 20'h100}));
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 20'h200);
    checkOutput("rd_flushed", 128'({inst_valid, imem_bus.imem_req_valid, imem_bus.imem_req_addr}), 128'({1'b0, 1'b1, 20'h200}));
    next_cycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 20'h200, 1'b0, 20'h0);
    checkOutput("rd_waiting", 128'(inst_valid), 128'(1'b0));
    next_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 20'h0);
    checkOutput("rd_target_word", 128'({inst_valid, pc, instruction}), 128'({1'b1, 20'h200, mem_word(20'h200)}));
    next_cycle();

    // Start-to-request and start-to-first-instruction latency.
    do_reset();
    lat_min = 1; lat_max = 1;
    start_cycle = cycle;
    first_req = -1;
    first_valid = -1;
    step_auto(1'b1, 1'b0, 1'b0, 20'h100, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step_auto(1'b0, 1'b0, 1'b0, 20'h0, 1'b1);
      if (first_req < 0 && s_req_valid) first_req = s_cycle;
      if (first_valid < 0 && s_inst_valid) first_valid = s_cycle;
    end
    checkOutput("start_to_req", 128'(first_req - start_cycle), 128'(1));
    checkOutput("start_to_valid", 128'(first_valid - start_cycle), 128'(FIRST_VALID_LAT));

    // Address wrap at the top of the 20-bit space.
    do_reset();
    lat_min = 1; lat_max = 2;
    step_auto(1'b1, 1'b0, 1'b0, 20'hFFFF8, 1'b1);
    for (int k = 0; k < 12; k++) step_auto(1'b0, 1'b0, 1'b0, 20'h0, 1'b1);
    checkOutput("wrap_req_count", 128'(acc_log.size() >= 3), 128'(1'b1));
    if (acc_log.size() >= 3) begin
      checkOutput("wrap_req0", 128'(acc_log[0]), 128'(20'hFFFF8));
      checkOutput("wrap_req1", 128'(acc_log[1]), 128'(20'hFFFFC));
      checkOutput("wrap_req2", 128'(acc_log[2]), 128'(20'h00000));
    end
    checkOutput("wrap_pops", 128'(pops >= 3), 128'(1'b1));

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat_min = 3; lat_max = 3;
    step_auto(1'b1, 1'b0, 1'b0, 20'h100, 1'b1);
    guard = 0;
    while (pending.size() < 2 && guard < 20) begin
      step_auto(1'b0, 1'b0, 1'b0, 20'h0, 1'b1);
      guard++;
    end
    checkOutput("two_in_flight", 128'(pending.size()), 128'(2));
    step_auto(1'b0, 1'b0, 1'b1, 20'h200, 1'b1);
    pops_before = pops;
    guard = 0;
    while (pops == pops_before && guard < 30) begin
      step_auto(1'b0, 1'b0, 1'b0, 20'h0, 1'b1);
      guard++;
    end
    checkOutput("redirect_first_pc", 128'({pops > pops_before, last_pop_pc}), 128'({1'b1, 20'h200}));

    // Randomized traffic against the reference model.
    do_reset();
    lat_min = 1; lat_max = 4;
    step_auto(1'b1, 1'b0, 1'b0, 20'h00F00, 1'b1);
    for (int k = 0; k < 500; k++) begin
      t = 20'($urandom);
      if ($urandom_range(2, 0) == 0) t = 20'hFFFF0 | 20'($urandom_range(15, 0));
      step_auto(1'b0, ($urandom_range(3, 0) == 0), ($urandom_range(24, 0) == 0), t, ($urandom_range(3, 0) != 0));
    end

    // Asynchronous reset mid-burst, then no activity until a new start.
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset_values");
    drive_idle();
    clear_model();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_auto(1'b0, 1'b0, 1'b0, 20'h0, 1'b1);
      checkOutput("idle_after_reset", 128'({s_req_valid, s_inst_valid}), 128'(2'b00));
    end
    step_auto(1'b1, 1'b0, 1'b0, 20'h00300, 1'b1);
    for (int k = 0; k < 60; k++) begin
      step_auto(1'b0, ($urandom_range(3, 0) == 0), ($urandom_range(19, 0) == 0), 20'($urandom), ($urandom_range(3, 0) != 0));
    end
    checkOutput("resume_after_restart", 128'(pops > 0), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode unit. It owns the fetch PC and issues sequential word requests to instruction memory over a valid/ready handshake. In-order responses are buffered in a small instruction queue, and the head is presented to decode as `PC`/`instruction`/`inst_valid`. Control redirects (branch, JAL, JALR targets selected downstream) flush the queue and discard responses still in flight.

## Interface
- `CORE`, 0, core index used in report output
- `ADDRESS_BITS`, 20, PC/address width
- `RESET_PC`, 0, value of `PC` and fetch PC after reset
- `QUEUE_DEPTH`, 2, instruction queue entries; power of two, ≥2
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  pulse: begin fetching at `start_PC`
- `start_PC`  in  ADDRESS_BITS  first fetch address
- `redirect`  in  1  pulse: control-flow change
- `redirect_target`  in  ADDRESS_BITS  new fetch address
- `imem_req_valid`  out  1  request presented
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  ADDRESS_BITS  request byte address
- `imem_rsp_valid`  in  1  response word valid; in order, ≥1 cycle after accept, no backpressure
- `imem_rsp_data`  in  32  instruction word
- `PC`  out  ADDRESS_BITS  address of the presented instruction
- `instruction`  out  32  presented instruction; `32'h00000013` (NOP) when `inst_valid`=0
- `inst_valid`  out  1  queue head valid
- `stall`  in  1  decode not accepting this cycle
- `report`  in  1  per-cycle `$display` of state, PCs, counts

## Operation
- States: IDLE (reset state; no requests) and RUN. IDLE→RUN on `start`: fetch_PC and rsp_PC ← `start_PC`. `start` in RUN is ignored. No transition RUN→IDLE except reset.
- Credit rule: outstanding + queue occupancy + drop_count ≤ QUEUE_DEPTH at all times. A response therefore always has a free slot.
- `imem_req_valid` = RUN && credit available && !`redirect`. `imem_req_addr` = fetch_PC. On accept, fetch_PC += 4 and outstanding++.
- Response, drop_count = 0: enqueue {rsp_PC, data}, rsp_PC += 4, outstanding--.
- Response, drop_count > 0: discard, drop_count--.
- Dequeue: head pops at the edge where `inst_valid` && !`stall`.
- Redirect, RUN only; ignored in IDLE:
  - Queue flushed, including a head that would pop this cycle.
  - drop_count ← drop_count + outstanding − (response this cycle ? 1 : 0); outstanding ← 0.
  - fetch_PC ← `redirect_target`, rsp_PC ← `redirect_target`.
- Address arithmetic is modulo 2^ADDRESS_BITS. 0xFFFFC + 4 wraps to 0x00000 (ADDRESS_BITS=20). Targets are used unaligned-as-given; bits [1:0] are not checked.
- Reset mid-operation clears the queue, outstanding and drop_count immediately. Responses for pre-reset requests arriving afterwards are the system's responsibility. Memory is reset together with the fetch unit.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `PC`=`RESET_PC`, `instruction`=NOP, `inst_valid`=0. State is IDLE; all counters 0.
- `start` at cycle S: first `imem_req_valid` at S+1.
- Request accepted at A, response at A+L: `inst_valid` with that word from A+L+1 (queue write latency 1).
- `redirect` at N: `imem_req_valid`=0 in N; first request to target at N+1 if credit allows. `inst_valid`=0 from N+1 until the target word arrives.
- Full queue: `imem_req_valid` stays 0 until a pop frees a credit. The request appears the cycle after the pop edge.
- Simultaneous pop and enqueue on a full queue is legal; occupancy is unchanged.
- Outputs `PC`/`instruction`/`inst_valid` are registered (queue head), except the bypass path below.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - A response that arrives with the queue empty, drop_count=0, !`stall` and no `redirect` drives `PC`/`instruction`/`inst_valid` combinationally in the same cycle (latency L).
  - It is not written to the queue and consumes no occupancy.
- Undefined: every response goes through the queue (latency L+1). All outputs are purely registered.

## Test plan
- Reset low then high, `start`=1 with `start_PC`=0x00100, memory latency 1, always ready, `stall`=0 → requests to 0x00100, 0x00104, …; decode sees `inst_valid` with PC 0x00100 at S+3 (S+2 with bypass), one instruction per cycle thereafter.
- `stall` held high 10 cycles → at most QUEUE_DEPTH requests outstanding+buffered. `imem_req_valid` drops, no response lost. After release, PCs continue without gaps or duplicates.
- Memory latency 3, `redirect` to 0x00200 with 2 requests in flight → both late responses discarded. Next presented PC is 0x00200 with its data; no stale instruction is ever valid.
- `redirect` in the same cycle as a response and a pop → queue empty next cycle, drop_count counts only the remaining in-flight requests, and no request is issued in the redirect cycle.
- `start_PC`=0xFFFF8, ADDRESS_BITS=20 → requests 0xFFFF8, 0xFFFFC, 0x00000; presented PCs match.
- Assert `reset`=0 asynchronously mid-burst → outputs return to reset values without a clock edge. `start` is required to resume.
